// File: rtl/fsm_seq_tx.sv
// fsm_seq_tx: serial frame transmitter.
// Sends a fixed preamble followed by a latched parallel payload, MSB first,
// one bit per clock, then a single GAP cycle that pulses done. A start seen
// in GAP chains the next frame without dropping busy.
module fsm_seq_tx #(
   parameter int               DATA_W   = 8,
   parameter int               PRE_W    = 3,
   parameter logic [PRE_W-1:0] PREAMBLE = 3'b010
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] data_in,
   output logic              y,
   output logic              busy,
   output logic              done
);

   // Counter must hold PRE_W-1 and DATA_W-1; never narrower than one bit.
   localparam int MAX_W = (PRE_W > DATA_W) ? PRE_W : DATA_W;
   localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PRE  = 2'd1,
      DATA = 2'd2,
      GAP  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              y_q, y_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [CNT_W-1:0]  cnt_dec;
   logic              pre_next_bit;

   // Select the preamble bit that will be on the line after the next edge.
   always_comb begin
      cnt_dec      = cnt_q - CNT_W'(1);
      pre_next_bit = 1'b0;
      for (int i = 0; i < PRE_W; i++) begin
         if (cnt_dec == CNT_W'(i)) begin
            pre_next_bit = PREAMBLE[i];
         end
      end
   end

   // Next-state and next-output logic; outputs are computed one cycle ahead so they can be registered.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      y_d     = 1'b0;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE, GAP: begin
            if (start) begin
               state_d = PRE;
               shift_d = data_in;
               cnt_d   = CNT_W'(PRE_W - 1);
               y_d     = PREAMBLE[PRE_W-1];
               busy_d  = 1'b1;
            end else begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         end
         PRE: begin
            busy_d = 1'b1;
            if (cnt_q == '0) begin
               state_d = DATA;
               cnt_d   = CNT_W'(DATA_W - 1);
               y_d     = shift_q[DATA_W-1];
            end else begin
               cnt_d = cnt_dec;
               y_d   = pre_next_bit;
            end
         end
         DATA: begin
            busy_d  = 1'b1;
            shift_d = shift_q << 1;
            if (cnt_q == '0) begin
               state_d = GAP;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_dec;
               y_d   = shift_d[DATA_W-1];
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            shift_d = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and registered outputs, cleared asynchronously by rst_n.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         y_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         y_q     <= y_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign y    = y_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_fsm_seq_tx.sv
// tb_fsm_seq_tx: checks two fsm_seq_tx instances (default parameters and a
// 1-bit/1-bit corner) against a frame-position model, plus directed literals.
module tb_fsm_seq_tx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start0 = 1'b0;
   logic [7:0] data0 = '0;
   logic       start1 = 1'b0;
   logic [0:0] data1 = '0;
   logic       y0, busy0, done0, y1, busy1, done1;

   int checks = 0;
   int errors = 0;
   bit en = 1'b0;

   always #5 clk = ~clk;

   fsm_seq_tx dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .data_in(data0),
      .y(y0), .busy(busy0), .done(done0)
   );

   fsm_seq_tx #(.DATA_W(1), .PRE_W(1), .PREAMBLE(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .data_in(data1),
      .y(y1), .busy(busy1), .done(done1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Frame as a list of line bits: bit k is what y carries k cycles after accept.
   function automatic logic [63:0] build(input int pw, input logic [7:0] pre,
                                         input int dw, input logic [31:0] d);
      logic [63:0] f = '0;
      for (int k = 0; k < pw; k++) f[k] = pre[pw-1-k];
      for (int k = 0; k < dw; k++) f[pw+k] = d[dw-1-k];
      return f;
   endfunction

   // Model: position within the current frame (-1 = idle).
   int          pos0 = -1, pos1 = -1;
   logic [63:0] fr0 = '0, fr1 = '0;
   localparam int LEN0 = 3 + 8 + 1;
   localparam int LEN1 = 1 + 1 + 1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos0 <= -1;
         pos1 <= -1;
      end else begin
         if ((pos0 == -1 || pos0 == LEN0-1) && start0) begin
            fr0 <= build(3, 8'b010, 8, {24'd0, data0});
            pos0 <= 0;
         end else if (pos0 == LEN0-1) pos0 <= -1;
         else if (pos0 >= 0) pos0 <= pos0 + 1;

         if ((pos1 == -1 || pos1 == LEN1-1) && start1) begin
            fr1 <= build(1, 8'b1, 1, {31'd0, data1});
            pos1 <= 0;
         end else if (pos1 == LEN1-1) pos1 <= -1;
         else if (pos1 >= 0) pos1 <= pos1 + 1;
      end
   end

   // Compare every cycle on the falling edge.
   always @(negedge clk) begin
      if (en) begin
         check("y0",    {31'd0, y0},    {31'd0, (pos0 >= 0) ? fr0[pos0] : 1'b0});
         check("busy0", {31'd0, busy0}, {31'd0, pos0 >= 0});
         check("done0", {31'd0, done0}, {31'd0, pos0 == LEN0-1});
         check("y1",    {31'd0, y1},    {31'd0, (pos1 >= 0) ? fr1[pos1] : 1'b0});
         check("busy1", {31'd0, busy1}, {31'd0, pos1 >= 0});
         check("done1", {31'd0, done1}, {31'd0, pos1 == LEN1-1});
      end
   end

   logic [11:0] seq, dmask;
   int          nbusy, nones, d_first, d_second;

   initial begin
      repeat (3) @(negedge clk);
      check("reset_y", {31'd0, y0}, 32'd0);
      check("reset_busy", {31'd0, busy0}, 32'd0);
      rst_n = 1'b1;
      en = 1'b1;

      // Idle with start low.
      repeat (5) @(negedge clk);

      // Single A5 frame: literal sequence, done position, busy length.
      data0 = 8'hA5; start0 = 1'b1;
      seq = '0; dmask = '0; nbusy = 0;
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         start0 = 1'b0;
         if (k < 12) begin
            seq = {seq[10:0], y0};
            dmask = {dmask[10:0], done0};
         end
         if (busy0) nbusy++;
      end
      check("a5_seq", {20'd0, seq}, {20'd0, 12'b010101001010});
      check("a5_done", {20'd0, dmask}, {20'd0, 12'b000000000001});
      check("a5_busy", nbusy, 12);

      // start held: data_in disturbed mid-DATA, both frames carry FF.
      data0 = 8'hFF; start0 = 1'b1; nones = 0;
      for (int k = 1; k <= 24; k++) begin
         @(negedge clk);
         if (k == 5) data0 = 8'h00;
         if (k == 10) data0 = 8'hFF;
         if (k == 14) start0 = 1'b0;
         if (y0) nones++;
      end
      check("held_ones", nones, 18);
      @(negedge clk);
      check("held_idle", {31'd0, busy0}, 32'd0);

      // Back-to-back: 3C then C3 requested in GAP.
      data0 = 8'h3C; start0 = 1'b1; nbusy = 0; d_first = -1; d_second = -1;
      for (int k = 1; k <= 25; k++) begin
         @(negedge clk);
         start0 = 1'b0;
         if (k == 12) begin start0 = 1'b1; data0 = 8'hC3; end
         if (busy0) nbusy++;
         if (done0) begin
            if (d_first < 0) d_first = k; else d_second = k;
         end
      end
      check("b2b_busy", nbusy, 24);
      check("b2b_done1", d_first, 12);
      check("b2b_period", d_second - d_first, 12);

      // Reset during 5th payload bit of 81.
      data0 = 8'h81; start0 = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         start0 = 1'b0;
      end
      #2 rst_n = 1'b0;
      #1;
      check("rst_y", {31'd0, y0}, 32'd0);
      check("rst_busy", {31'd0, busy0}, 32'd0);
      check("rst_done", {31'd0, done0}, 32'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("rst_stay_idle", {31'd0, busy0}, 32'd0);
      start0 = 1'b1; seq = '0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         start0 = 1'b0;
         seq = {seq[10:0], y0};
      end
      check("81_seq", {20'd0, seq}, {20'd0, 12'b010100000010});

      // 1-bit corner instance.
      repeat (2) @(negedge clk);
      data1 = 1'b1; start1 = 1'b1; seq = '0; dmask = '0; nbusy = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         start1 = 1'b0;
         if (k < 3) begin
            seq = {seq[10:0], y1};
            dmask = {dmask[10:0], done1};
         end
         if (busy1) nbusy++;
      end
      check("w1_seq", {29'd0, seq[2:0]}, 32'b110);
      check("w1_done", {29'd0, dmask[2:0]}, 32'b001);
      check("w1_busy", nbusy, 3);

      // Random traffic on both instances.
      for (int k = 0; k < 600; k++) begin
         @(negedge clk);
         start0 = ($urandom_range(0, 2) == 0);
         data0  = 8'($urandom);
         start1 = ($urandom_range(0, 1) == 0);
         data1  = 1'($urandom);
      end
      start0 = 1'b0; start1 = 1'b0;
      repeat (15) @(negedge clk);
      check("final_idle", {31'd0, busy0}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fsm_seq_tx.md
# fsm_seq_tx

Serial frame transmitter: the transmit-side counterpart of the team's serial sequence-detector FSMs. On a start request it latches a parallel word and drives it onto a single-bit line `y` as a fixed preamble followed by the payload, MSB first, one bit per clock. A detector on the far end recognises the frame by the preamble. Sits between a parallel producer and the serial line.

## Interface
- `DATA_W`, 8: payload width in bits; legal range 1–32.
- `PRE_W`, 3: preamble width in bits; legal range 1–8.
- `PREAMBLE`, 3'b010: preamble pattern, sent MSB first; width `PRE_W`.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset; deassertion is synchronous to `clk` externally.
- `start`  in  1  frame request; sampled on the rising edge only when the FSM is in IDLE or GAP.
- `data_in`  in  `DATA_W`  payload; latched on the edge that accepts `start`.
- `y`  out  1  serial line, registered; idle level 0.
- `busy`  out  1  registered; 1 from the accept edge until the FSM returns to IDLE.
- `done`  out  1  registered; 1-cycle pulse during the GAP cycle of each completed frame.

## Operation
- Moore-style FSM with four states: IDLE, PRE, DATA and GAP. All outputs are registered, with no combinational path from inputs to outputs.
- IDLE:
  - `y`=0, `busy`=0, `done`=0.
  - If `start`=1 → PRE. On the same edge, load `shift_q` ← `data_in`, set `cnt` ← `PRE_W`-1, and drive `y` ← `PREAMBLE[PRE_W-1]`.
- PRE:
  - Each cycle `y` carries preamble bit `PREAMBLE[cnt]`.
  - When `cnt`=0 → DATA. Set `cnt` ← `DATA_W`-1 and drive `y` ← `shift_q[DATA_W-1]`.
  - Otherwise `cnt` decrements and the next preamble bit is driven.
- DATA:
  - Each cycle `y` carries `shift_q` MSB. The register shifts left each edge, filling with 0.
  - When `cnt`=0 → GAP. Drive `y` ← 0 and `done` ← 1.
- GAP: one cycle with `y`=0, `done`=1, `busy`=1.
  - If `start`=1 → PRE, with the same loads as IDLE→PRE (back-to-back frames).
  - Otherwise → IDLE.
- `start` is ignored in PRE and DATA: no queuing, and `data_in` is not sampled.
- `cnt` width is clog2(max(`PRE_W`, `DATA_W`)), minimum 1 bit. `cnt` never wraps below 0, because the state changes on `cnt`=0.
- Invalid or unreachable state encodings → IDLE on the next edge, with `y`=0.

## Timing
- Reset (`rst_n`=0, any time): state=IDLE, `y`=0, `busy`=0, `done`=0, `shift_q`=0, `cnt`=0. These take effect immediately (asynchronous).
- Reset mid-frame aborts the frame with no `done` pulse. After release, the FSM waits in IDLE for a new `start`.
- Let E0 be the accept edge:
  - `busy` and the first preamble bit are visible after E0.
  - Preamble occupies cycles after E0 .. E0+`PRE_W`-1.
  - Payload occupies cycles after E0+`PRE_W` .. E0+`PRE_W`+`DATA_W`-1.
  - GAP (`y`=0, `done`=1) follows E0+`PRE_W`+`DATA_W`.
  - IDLE (`busy`=0) follows E0+`PRE_W`+`DATA_W`+1.
- `busy` is high for exactly `PRE_W`+`DATA_W`+1 cycles per frame.
- Back-to-back: minimum frame period is `PRE_W`+`DATA_W`+1 cycles. `busy` stays 1 continuously across frames.
- `start` held high permanently → frames repeat with period `PRE_W`+`DATA_W`+1. `data_in` is re-sampled at each GAP→PRE edge.
- `done` is never high for 2 consecutive cycles, and never outside GAP.

## Test plan
- Reset, then idle for 5 cycles with `start`=0 → `y`=0, `busy`=0 and `done`=0 throughout.
- Defaults, `data_in`=8'hA5, `start` pulsed 1 cycle:
  - `y` sequence after the accept edge is 0,1,0, 1,0,1,0,0,1,0,1, 0.
  - `done`=1 only on the 12th cycle.
  - `busy` is high for 12 cycles.
- `start` held high, `data_in`=8'hFF then 8'h00 (changed during the first frame's DATA phase) → both frames send 8'hFF; `data_in` changes are ignored mid-frame.
- Back-to-back: with 8'h3C accepted, assert `start` with `data_in`=8'hC3 in the GAP cycle:
  - The second preamble starts the next cycle.
  - `busy` never drops.
  - Two `done` pulses occur 12 cycles apart.
- `rst_n` asserted during the 5th payload bit of 8'h81 → `y`, `busy` and `done` go to 0 immediately, with no `done` pulse. After release plus a new `start` with 8'h81, a full correct frame follows.
- Parameter sweep `DATA_W`=1, `PRE_W`=1, `PREAMBLE`=1'b1, `data_in`=1'b1 → `y` reads 1,1,0, `done` is high in cycle 3, and `busy` is high for 3 cycles.
